// File: rtl/axi_multi_chan_logger.sv
// rtl/axi_multi_chan_logger.sv - timestamped multi-channel AXI address logger
// Per-channel capture buffers feed a round-robin arbiter that writes one log RAM entry per cycle.
module axi_multi_chan_logger #(
  parameter int NUM_CH         = 2,
  parameter int AXI_ADDR_BITW  = 32,
  parameter int AXI_ID_BITW    = 8,
  parameter int AXI_LEN_BITW   = 8,
  parameter int TIMESTAMP_BITW = 32,
  parameter int DEPTH          = 1024,
  parameter int FIFO_DEPTH     = 4,
  parameter int AF_MARGIN      = 64,
  parameter int DROP_CNT_BITW  = 16,
  localparam int CH_BITW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_BITW   = $clog2(DEPTH),
  localparam int ENTRY_BITW = TIMESTAMP_BITW + AXI_ADDR_BITW + AXI_ID_BITW + AXI_LEN_BITW + CH_BITW
) (
  input  logic                            Clk_CI,
  input  logic                            Rst_RI,
  input  logic [NUM_CH-1:0]               AxiValid_SI,
  input  logic [NUM_CH-1:0]               AxiReady_SI,
  input  logic [NUM_CH*AXI_ADDR_BITW-1:0] AxiAddr_DI,
  input  logic [NUM_CH*AXI_ID_BITW-1:0]   AxiId_DI,
  input  logic [NUM_CH*AXI_LEN_BITW-1:0]  AxiLen_DI,
  input  logic                            Enable_SI,
  input  logic                            RingMode_SI,
  input  logic                            Clear_SI,
  input  logic                            RdEn_SI,
  input  logic [PTR_BITW-1:0]             RdAddr_DI,
  output logic [ENTRY_BITW-1:0]           RdData_DO,
  output logic [PTR_BITW:0]               Count_DO,
  output logic [PTR_BITW-1:0]             WrPtr_DO,
  output logic                            Full_SO,
  output logic                            AlmostFull_SO,
  output logic                            Wrapped_SO,
  output logic [DROP_CNT_BITW-1:0]        DropCnt_DO
);

  localparam int FIFO_BITW = $clog2(FIFO_DEPTH);
  localparam int LP_AF_TH  = (DEPTH > AF_MARGIN) ? DEPTH - AF_MARGIN : 0;
  localparam logic [PTR_BITW:0]        LP_DEPTH    = (PTR_BITW+1)'(DEPTH);
  localparam logic [PTR_BITW:0]        LP_AF       = (PTR_BITW+1)'(LP_AF_TH);
  localparam logic [FIFO_BITW:0]       LP_FDEPTH   = (FIFO_BITW+1)'(FIFO_DEPTH);
  localparam logic [DROP_CNT_BITW-1:0] LP_DROP_MAX = '1;

  logic [TIMESTAMP_BITW-1:0] r_ts;
  logic [CH_BITW-1:0]        r_rr;
  logic [PTR_BITW-1:0]       r_wrptr;
  logic [PTR_BITW:0]         r_count;
  logic                      r_wrapped;
  logic [DROP_CNT_BITW-1:0]  r_drop;
  logic [ENTRY_BITW-1:0]     r_rd_data;
  logic [ENTRY_BITW-1:0]     r_ram [DEPTH];
  logic [ENTRY_BITW-1:0]     r_fifo [NUM_CH][FIFO_DEPTH];
  logic [FIFO_BITW-1:0]      r_fwr [NUM_CH];
  logic [FIFO_BITW-1:0]      r_frd [NUM_CH];
  logic [FIFO_BITW:0]        r_fcnt [NUM_CH];

  logic [NUM_CH-1:0]         w_cap, w_push, w_drop, w_nonempty, w_pop_ch;
  logic [ENTRY_BITW-1:0]     w_entry [NUM_CH];
  logic [CH_BITW-1:0]        w_grant;
  logic                      w_grant_vld, w_pop_ok, w_pop;
  logic [ENTRY_BITW-1:0]     w_head;
  logic [7:0]                w_ndrop;
  logic [DROP_CNT_BITW+7:0]  w_drop_sum;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cap[i]      = AxiValid_SI[i] & AxiReady_SI[i] & Enable_SI & ~Clear_SI;
      w_nonempty[i] = (r_fcnt[i] != '0);
      w_entry[i]    = {CH_BITW'(i), AxiLen_DI[i*AXI_LEN_BITW +: AXI_LEN_BITW],
                       AxiId_DI[i*AXI_ID_BITW +: AXI_ID_BITW],
                       AxiAddr_DI[i*AXI_ADDR_BITW +: AXI_ADDR_BITW], r_ts};
    end
  end

  // Round-robin: first non-empty buffer at or after the RR pointer wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_grant_vld && w_nonempty[(int'(r_rr) + k) % NUM_CH]) begin
        w_grant_vld = 1'b1;
        w_grant     = CH_BITW'((int'(r_rr) + k) % NUM_CH);
      end
    end
  end

  assign w_pop_ok = RingMode_SI | (r_count < LP_DEPTH);
  assign w_pop    = w_grant_vld & w_pop_ok & ~Clear_SI;
  assign w_head   = r_fifo[w_grant][r_frd[w_grant]];

  // A full buffer still accepts a push when it is popped in the same cycle.
  always_comb begin
    w_pop_ch = '0;
    w_push   = '0;
    w_drop   = '0;
    w_ndrop  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop_ch[i] = w_pop && (int'(w_grant) == i);
      w_push[i]   = w_cap[i] & ((r_fcnt[i] != LP_FDEPTH) | w_pop_ch[i]);
      w_drop[i]   = w_cap[i] & (r_fcnt[i] == LP_FDEPTH) & ~w_pop_ch[i];
      w_ndrop     = w_ndrop + 8'(w_drop[i]);
    end
    w_drop_sum = {8'd0, r_drop} + {{DROP_CNT_BITW{1'b0}}, w_ndrop};
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_fwr[i]  <= '0;
        r_frd[i]  <= '0;
        r_fcnt[i] <= '0;
      end
    end else if (Clear_SI) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_fwr[i]  <= '0;
        r_frd[i]  <= '0;
        r_fcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i])   r_fwr[i] <= r_fwr[i] + 1'b1;
        if (w_pop_ch[i]) r_frd[i] <= r_frd[i] + 1'b1;
        r_fcnt[i] <= r_fcnt[i] + (FIFO_BITW+1)'(w_push[i]) - (FIFO_BITW+1)'(w_pop_ch[i]);
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i]) r_fifo[i][r_fwr[i]] <= w_entry[i];
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_ts      <= '0;
      r_rr      <= '0;
      r_wrptr   <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_drop    <= '0;
    end else if (Clear_SI) begin
      r_ts      <= '0;
      r_rr      <= '0;
      r_wrptr   <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_drop_sum > {8'd0, LP_DROP_MAX}) r_drop <= LP_DROP_MAX;
      else                                  r_drop <= w_drop_sum[DROP_CNT_BITW-1:0];
      if (w_pop) begin
        r_rr    <= CH_BITW'((int'(w_grant) + 1) % NUM_CH);
        r_wrptr <= r_wrptr + 1'b1;
        if (r_count != LP_DEPTH) r_count   <= r_count + 1'b1;
        else                     r_wrapped <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (w_pop) r_ram[r_wrptr] <= w_head;
  end

  // Same-cycle read of the slot being written returns the previous content.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI)       r_rd_data <= '0;
    else if (RdEn_SI) r_rd_data <= r_ram[RdAddr_DI];
  end

  assign RdData_DO     = r_rd_data;
  assign Count_DO      = r_count;
  assign WrPtr_DO      = r_wrptr;
  assign Wrapped_SO    = r_wrapped;
  assign DropCnt_DO    = r_drop;
  assign Full_SO       = ~RingMode_SI & (r_count == LP_DEPTH);
  assign AlmostFull_SO = (r_count >= LP_AF);

endmodule

// File: tb/tb_axi_multi_chan_logger.sv
// tb/tb_axi_multi_chan_logger.sv - directed self-checking bench for axi_multi_chan_logger
// Small log (DEPTH=16, FIFO_DEPTH=4, AF_MARGIN=4) so full, ring and drop cases are reachable.
module tb_axi_multi_chan_logger;

  localparam int EW = 81;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  valid = '0;
  logic [1:0]  ready = '0;
  logic [63:0] addr = '0;
  logic [15:0] id = {8'h21, 8'h20};
  logic [15:0] len = {8'h31, 8'h30};
  logic        enable = 1'b0;
  logic        ring = 1'b0;
  logic        clear = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [EW-1:0] rd_data;
  logic [4:0]  count;
  logic [3:0]  wr_ptr;
  logic        full, afull, wrapped;
  logic [15:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] e [8];
  logic [31:0] ts0;

  axi_multi_chan_logger #(
    .DEPTH(16), .FIFO_DEPTH(4), .AF_MARGIN(4)
  ) dut (
    .Clk_CI(clk), .Rst_RI(rst), .AxiValid_SI(valid), .AxiReady_SI(ready),
    .AxiAddr_DI(addr), .AxiId_DI(id), .AxiLen_DI(len), .Enable_SI(enable),
    .RingMode_SI(ring), .Clear_SI(clear), .RdEn_SI(rd_en), .RdAddr_DI(rd_addr),
    .RdData_DO(rd_data), .Count_DO(count), .WrPtr_DO(wr_ptr), .Full_SO(full),
    .AlmostFull_SO(afull), .Wrapped_SO(wrapped), .DropCnt_DO(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1);
    valid = m;
    ready = 2'b11;
    addr  = {a1, a0};
    tick();
    valid = '0;
  endtask

  task automatic rd(input int idx, output logic [EW-1:0] d);
    rd_en   = 1'b1;
    rd_addr = 4'(idx);
    tick();
    rd_en   = 1'b0;
    d       = rd_data;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [EW-1:0] ent(input logic ch, input logic [31:0] a, input logic [31:0] ts);
    return ch ? {1'b1, 8'h31, 8'h21, a, ts} : {1'b0, 8'h30, 8'h20, a, ts};
  endfunction

  initial begin
    // reset state
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_wrptr", wr_ptr, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_rddata", rd_data, 0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // 1: three ch0 beats, latency and timestamp spacing
    beat(2'b01, 32'h100, 0);
    beat(2'b01, 32'h104, 0);
    beat(2'b01, 32'h108, 0);
    chk("t1_count_n1", count, 2);
    tick();
    chk("t1_count_n2", count, 3);
    chk("t1_wrptr", wr_ptr, 3);
    for (int k = 0; k < 3; k++) rd(k, e[k]);
    ts0 = e[0][31:0];
    for (int k = 0; k < 3; k++)
      chk($sformatf("t1_entry%0d", k), e[k], ent(1'b0, 32'h100 + 32'(4*k), ts0 + 32'(k)));

    // 2: both channels together, alternating order, shared timestamps from 0
    do_clear();
    for (int k = 0; k < 4; k++) beat(2'b11, 32'h200 + 32'(4*k), 32'h300 + 32'(4*k));
    for (int k = 0; k < 8; k++) tick();
    chk("t2_count", count, 8);
    chk("t2_drop", drop_cnt, 0);
    for (int k = 0; k < 8; k++) rd(k, e[k]);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_ch0_%0d", k), e[2*k], ent(1'b0, 32'h200 + 32'(4*k), 32'(k)));
      chk($sformatf("t2_ch1_%0d", k), e[2*k+1], ent(1'b1, 32'h300 + 32'(4*k), 32'(k)));
    end

    // 3: stop mode fill, buffer fill, drops, almost-full threshold
    do_clear();
    for (int j = 0; j < 24; j++) begin
      beat(2'b01, 32'h500 + 32'(4*j), 0);
      if (j == 11) begin
        chk("t3_count11", count, 11);
        chk("t3_afull11", afull, 0);
      end
      if (j == 12) begin
        chk("t3_count12", count, 12);
        chk("t3_afull12", afull, 1);
      end
    end
    tick(); tick();
    chk("t3_count", count, 16);
    chk("t3_full", full, 1);
    chk("t3_afull", afull, 1);
    chk("t3_drop", drop_cnt, 4);
    chk("t3_wrptr", wr_ptr, 0);
    ring = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("t3_ring_wrptr", wr_ptr, 4);
    chk("t3_ring_count", count, 16);
    chk("t3_ring_wrapped", wrapped, 1);
    chk("t3_ring_full", full, 0);
    rd(0, e[0]);
    rd(3, e[3]);
    chk("t3_idx0_addr", e[0][63:32], 32'h540);
    chk("t3_idx3_addr", e[3][63:32], 32'h54C);
    ring = 1'b0;
    #1;
    chk("t3_full_on_stop", full, 1);
    ring = 1'b1;
    tick();

    // 4: ring mode overwrite
    do_clear();
    for (int j = 0; j < 20; j++) beat(2'b01, 32'h600 + 32'(4*j), 0);
    for (int k = 0; k < 4; k++) tick();
    chk("t4_count", count, 16);
    chk("t4_wrptr", wr_ptr, 4);
    chk("t4_wrapped", wrapped, 1);
    chk("t4_full", full, 0);
    chk("t4_drop", drop_cnt, 0);
    rd(0, e[0]);
    rd(3, e[3]);
    rd(4, e[4]);
    chk("t4_idx0_addr", e[0][63:32], 32'h640);
    chk("t4_idx3_addr", e[3][63:32], 32'h64C);
    chk("t4_idx4_addr", e[4][63:32], 32'h610);

    // 5: clear coincident with handshake while buffers hold beats
    ring = 1'b0;
    beat(2'b01, 32'h800, 0);
    beat(2'b01, 32'h804, 0);
    tick();
    chk("t5_pre_count", count, 16);
    chk("t5_pre_drop", drop_cnt, 0);
    valid = 2'b01;
    addr  = {32'h0, 32'h999};
    clear = 1'b1;
    tick();
    clear = 1'b0;
    valid = '0;
    chk("t5_count", count, 0);
    chk("t5_wrptr", wr_ptr, 0);
    chk("t5_wrapped", wrapped, 0);
    chk("t5_drop", drop_cnt, 0);
    chk("t5_full", full, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("t5_count_later", count, 0);
    rd(0, e[0]);
    chk("t5_old_idx0", e[0][63:32], 32'h640);

    // 6: asynchronous reset mid-burst
    ring = 1'b1;
    for (int j = 0; j < 4; j++) beat(2'b01, 32'hA00 + 32'(4*j), 0);
    chk("t6_pre_count", count, 3);
    valid = 2'b01;
    #3 rst = 1'b1;
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_wrptr", wr_ptr, 0);
    chk("t6_async_rddata", rd_data, 0);
    valid = '0;
    #2 rst = 1'b0;
    tick();
    beat(2'b01, 32'h700, 0);
    beat(2'b01, 32'h704, 0);
    tick(); tick();
    chk("t6_count", count, 2);
    chk("t6_wrptr", wr_ptr, 2);
    rd(0, e[0]);
    rd(1, e[1]);
    chk("t6_idx0_addr", e[0][63:32], 32'h700);
    chk("t6_idx1_addr", e[1][63:32], 32'h704);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
